// File: rtl/fp8_mul_scheduler.sv
// Round-robin scheduler sharing one e4m3 multiplier among N_REQ requesters.
// Optional WAIT timeout with error flag enabled by defining FP8_SCHED_TIMEOUT_EN.
module fp8_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [7:0]         mul_y,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_y,
`ifdef FP8_SCHED_TIMEOUT_EN
    output logic               rsp_err,
`endif
    input  logic [N_REQ-1:0]   rsp_ready
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] g_q, g_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    y_q, y_d;

    logic [PW-1:0] gnt;
    logic          any_req;
    logic [PW:0]   idx_w;
    logic [7:0]    a_sel;
    logic [7:0]    b_sel;

`ifdef FP8_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Search starts at ptr and wraps; first valid requester wins.
    always_comb begin
        gnt     = '0;
        any_req = 1'b0;
        idx_w   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_w >= (PW+1)'(N_REQ)) begin
                idx_w = idx_w - (PW+1)'(N_REQ);
            end
            if (!any_req && req_valid[idx_w[PW-1:0]]) begin
                any_req = 1'b1;
                gnt     = idx_w[PW-1:0];
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt == PW'(i)) begin
                a_sel = req_a[8*i +: 8];
                b_sel = req_b[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
`ifdef FP8_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    g_d     = gnt;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    state_d = S_ISSUE;
`ifdef FP8_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FP8_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (mul_done) begin
                    y_d     = mul_y;
                    state_d = S_RESP;
                end
`ifdef FP8_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    y_d     = 8'h7F;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready[g_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
`ifdef FP8_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
`ifdef FP8_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // req_ready is combinational from req_valid, so it must be gated by reset itself.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = !reset && (state_q == S_IDLE) && any_req && (gnt == PW'(i));
            rsp_valid[i] = !reset && (state_q == S_RESP) && (g_q == PW'(i));
        end
    end

    assign mul_start = !reset && (state_q == S_ISSUE);
    assign mul_a     = (!reset && (state_q == S_ISSUE || state_q == S_WAIT)) ? a_q : '0;
    assign mul_b     = (!reset && (state_q == S_ISSUE || state_q == S_WAIT)) ? b_q : '0;
    assign rsp_y     = y_q;
`ifdef FP8_SCHED_TIMEOUT_EN
    assign rsp_err   = !reset && (state_q == S_RESP) && err_q;
`endif

endmodule

// File: doc/fp8_mul_scheduler.md
FP8_MUL_SCHEDULER -- requirements
Module: fp8_mul_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one e4m3 multiplier (2..8).
REQ-002 Parameter TIMEOUT, default 16, WAIT-state cycle limit, used only when FP8_SCHED_TIMEOUT_EN is defined.
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port req_valid  input  N_REQ  per-requester operation request.
REQ-006 Port req_a  input  8*N_REQ  e4m3 operand A; requester i uses bits [8i+7:8i].
REQ-007 Port req_b  input  8*N_REQ  e4m3 operand B, same packing as req_a.
REQ-008 Port req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-009 Port mul_a, mul_b  output  8 each  operands driven to the shared multiplier.
REQ-010 Port mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 Port mul_done  input  1  multiplier result valid.
REQ-012 Port mul_y  input  8  multiplier e4m3 result.
REQ-013 Port rsp_valid  output  N_REQ  per-requester response valid; one-hot or zero.
REQ-014 Port rsp_y  output  8  response data, shared by all requesters.
REQ-015 Port rsp_ready  input  N_REQ  per-requester response accept.
REQ-016 Port rsp_err  output  1  timeout flag for the current response; present only with FP8_SCHED_TIMEOUT_EN.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; the scheduler SHALL hold exactly one operation in flight.
REQ-018 IDLE: if any req_valid bit is set, select grant g round-robin, starting the search at pointer ptr and wrapping from N_REQ-1 to 0.
REQ-019 IDLE: req_ready[g] is driven combinationally in the same cycle; on that edge, capture req_a/req_b slice g and g into registers, then go to ISSUE.
REQ-020 req_ready SHALL be zero in every state except IDLE.
REQ-021 ISSUE: mul_start=1 for exactly one cycle, then go to WAIT.
REQ-022 mul_a and mul_b SHALL show the captured operands from ISSUE until leaving WAIT; they are 8'h00 otherwise.
REQ-023 mul_done is sampled only in WAIT; a pulse in IDLE, ISSUE or RESP is ignored.
REQ-024 WAIT: on mul_done, capture mul_y into rsp_y and go to RESP.
REQ-025 RESP: rsp_valid[g]=1 and rsp_y stays stable until rsp_ready[g]=1. Then go to IDLE and set ptr=(g+1) mod N_REQ.
REQ-026 rsp_ready bits of non-granted requesters SHALL be ignored.
REQ-027 Minimum latency: acceptance edge to rsp_valid is 3 cycles when mul_done arrives in the first WAIT cycle.
REQ-028 A requester dropping req_valid after acceptance SHALL NOT affect the operation in flight.
REQ-029 A new request is accepted no earlier than the cycle after the RESP handshake, so there is no back-to-back overlap.

Reset
REQ-030 Asynchronous reset SHALL force IDLE, ptr=0, g=0, and clear captured operands and rsp_y to 8'h00.
REQ-031 During reset: req_ready=0, rsp_valid=0, mul_start=0, mul_a=mul_b=0, rsp_err=0.
REQ-032 Reset mid-operation SHALL abandon the operation with no response; a late mul_done after release is ignored.

Configuration
REQ-033 Macro FP8_SCHED_TIMEOUT_EN: when defined, a WAIT counter runs.
REQ-034 With FP8_SCHED_TIMEOUT_EN, when the counter reaches TIMEOUT cycles without mul_done: go to RESP with rsp_y=8'h7F (NaN) and rsp_err=1.
REQ-035 With FP8_SCHED_TIMEOUT_EN, rsp_err SHALL be 0 for normal responses.
REQ-036 Without FP8_SCHED_TIMEOUT_EN, there is no counter and no rsp_err port, and WAIT lasts indefinitely.

Verification
REQ-037 Single request: req_valid=4'b0001, a=8'h38, b=8'h40, mul_done 1 cycle after mul_start with mul_y=8'h40. Required: req_ready[0] in cycle 0, mul_start in cycle 1, rsp_valid=4'b0001 with rsp_y=8'h40 in cycle 3.
REQ-038 Fairness: req_valid=4'b1111 held continuously. Required: grant order 0,1,2,3,0 and req_ready never multi-hot.
REQ-039 Backpressure: rsp_ready held 0 for 5 cycles in RESP. Required: rsp_valid and rsp_y stable, req_ready=0 throughout, IDLE entered one cycle after rsp_ready=1.
REQ-040 Reset in WAIT, then mul_done pulse after release. Required: all outputs 0 and no rsp_valid.
REQ-041 With FP8_SCHED_TIMEOUT_EN and TIMEOUT=16, mul_done never asserted. Required: after 16 WAIT cycles, rsp_y=8'h7F and rsp_err=1.
REQ-042 Stray mul_done asserted in IDLE. Required: no state change.
